muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M-style multiply/divide unit: iterative shift-add and restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [XLEN-1:0]  DATA1,
  input  logic [XLEN-1:0]  DATA2,
  input  logic [TAG_W-1:0] TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  RESULT,
  output logic [TAG_W-1:0] OUT_TAG
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_n;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [CW-1:0]    cnt_q;
  logic [XLEN-1:0]  res_q;

  logic            accept;
  logic            is_div;
  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            neg_in;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  assign IN_READY  = (state_q == IDLE) && !RESET;
  assign OUT_VALID = (state_q == DONE);
  assign RESULT    = OUT_VALID ? res_q : '0;
  assign OUT_TAG   = OUT_VALID ? tag_q : '0;

  assign accept = IN_VALID && IN_READY && !FLUSH;
  assign is_div = OP[2];

  // MUL is treated as signed x signed; its low half is sign-agnostic.
  assign a_sgn = is_div ? !OP[0] : (OP != 3'b011);
  assign b_sgn = is_div ? !OP[0] : !OP[1];
  assign a_neg = a_sgn && DATA1[XLEN-1];
  assign b_neg = b_sgn && DATA2[XLEN-1];
  assign a_mag = a_neg ? -DATA1 : DATA1;
  assign b_mag = b_neg ? -DATA2 : DATA2;

  assign div_zero = is_div && (DATA2 == '0);
  assign div_ovf  = is_div && !OP[0] && (DATA1 == MIN) && (DATA2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = OP[1] ? DATA1 : '1;
    else if (div_ovf)
      special_res = OP[1] ? '0 : DATA1;
  end

  // Remainder follows the dividend sign; everything else uses sign xor.
  assign neg_in = (is_div && OP[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;

  assign fast_prod = (2*XLEN)'(
    $signed({a_neg, DATA1}) * $signed({b_neg, DATA2}));
  assign fast     = !is_div;
  assign fast_res = (OP[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                       : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     r_sh;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    r_sh    = {hi_q, lo_q[XLEN-1]};
    diff    = r_sh - {1'b0, b_q};
    if (op_q[2]) begin
      hi_n = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], !diff[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod    = {hi_n, lo_n};
    prod_s  = neg_q ? -prod : prod;
    div_val = op_q[1] ? hi_n : lo_n;
    if (op_q[2])
      calc_res = neg_q ? -div_val : div_val;
    else if (op_q[1:0] == 2'b00)
      calc_res = prod_s[XLEN-1:0];
    else
      calc_res = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_n = (special || fast) ? DONE : CALC;
      CALC:
        if (FLUSH)
          state_n = IDLE;
        else if (cnt_q == LAST)
          state_n = DONE;
      DONE:
        if (FLUSH || OUT_READY)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  // Dividend/multiplier share lo_q; divisor/multiplicand live in b_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q  <= '0;
      neg_q <= 1'b0;
      tag_q <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q  <= OP;
      neg_q <= neg_in;
      tag_q <= TAG;
      b_q   <= is_div ? b_mag : a_mag;
      hi_q  <= '0;
      lo_q  <= is_div ? a_mag : b_mag;
      cnt_q <= '0;
      res_q <= special ? special_res : fast_res;
    end else if (state_q == CALC && !FLUSH) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST)
        res_q <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit at XLEN=32.
// Covers latency, special divides, back-pressure, flush and reset.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, IN_VALID, IN_READY;
  logic [2:0]  OP;
  logic [31:0] DATA1, DATA2, RESULT;
  logic [4:0]  TAG, OUT_TAG;
  logic        OUT_VALID, OUT_READY;

  muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .DATA1(DATA1), .DATA2(DATA2), .TAG(TAG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .OUT_TAG(OUT_TAG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[20];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] tag,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    int w;
    IN_VALID = 1'b1;
    OP = v.op; DATA1 = v.a; DATA2 = v.b; TAG = v.tag;
    w = 0;
    while (!IN_READY && w < 50) begin
      tick();
      w++;
    end
    tick();
    IN_VALID = 1'b0;
  endtask

  // Returns edges from the accepting edge until OUT_VALID was seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!OUT_VALID && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    issue(v);
    wait_done(lat);
    check({nm, ".valid"}, 64'(OUT_VALID), 64'd1);
    check({nm, ".lat"}, 64'(lat), 64'(v.lat));
    check({nm, ".result"}, 64'(RESULT), 64'(v.exp));
    check({nm, ".tag"}, 64'(OUT_TAG), 64'(v.tag));
    if (OUT_READY) tick();
  endtask

  initial begin
    int lat, pulses;
    vec_t v;

    vt[0]  = mk(3'b000, 32'h7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, ML);
    vt[1]  = mk(3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, ML);
    vt[2]  = mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, ML);
    vt[3]  = mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, ML);
    vt[4]  = mk(3'b000, 32'h12345678, 32'h10,       5'd4,  32'h23456780, ML);
    vt[5]  = mk(3'b001, 32'hFFFFFFFF, 32'h5,        5'd5,  32'hFFFFFFFF, ML);
    vt[6]  = mk(3'b011, 32'h80000000, 32'h2,        5'd6,  32'h1,        ML);
    vt[7]  = mk(3'b100, 32'hFFFFFFF9, 32'h2,        5'd7,  32'hFFFFFFFD, 33);
    vt[8]  = mk(3'b110, 32'hFFFFFFF9, 32'h2,        5'd8,  32'hFFFFFFFF, 33);
    vt[9]  = mk(3'b101, 32'hFFFFFFFF, 32'h2,        5'd10, 32'h7FFFFFFF, 33);
    vt[10] = mk(3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        33);
    vt[11] = mk(3'b100, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33);
    vt[12] = mk(3'b110, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        33);
    vt[13] = mk(3'b100, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
    vt[14] = mk(3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        1);
    vt[15] = mk(3'b101, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1);
    vt[16] = mk(3'b111, 32'd5,        32'd0,        5'd17, 32'd5,        1);
    vt[17] = mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
    vt[18] = mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1);
    vt[19] = mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        33);

    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    OP = '0; DATA1 = '0; DATA2 = '0; TAG = '0;
    tick();
    tick();
    check("rst.in_ready", 64'(IN_READY), 64'd0);
    check("rst.out_valid", 64'(OUT_VALID), 64'd0);
    check("rst.result", 64'(RESULT), 64'd0);
    check("rst.out_tag", 64'(OUT_TAG), 64'd0);
    RESET = 1'b0;
    tick();
    check("rst.ready_after", 64'(IN_READY), 64'd1);

    for (int i = 0; i < 20; i++)
      run_vec($sformatf("vec%0d", i), vt[i]);

    // Back-pressure: result held while OUT_READY is low.
    OUT_READY = 1'b0;
    run_vec("bp", mk(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 33));
    IN_VALID = 1'b1; OP = 3'b100; DATA1 = 32'd5; DATA2 = 32'd0; TAG = 5'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.valid", 64'(OUT_VALID), 64'd1);
      check("bp.result", 64'(RESULT), 64'd14);
      check("bp.tag", 64'(OUT_TAG), 64'd3);
      check("bp.in_ready", 64'(IN_READY), 64'd0);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("bp.release_valid", 64'(OUT_VALID), 64'd0);
    check("bp.release_ready", 64'(IN_READY), 64'd1);
    check("bp.release_result", 64'(RESULT), 64'd0);

    // FLUSH in IDLE blocks acceptance of a special divide.
    IN_VALID = 1'b1; OP = 3'b100; DATA1 = 32'd5; DATA2 = 32'd0; TAG = 5'd2;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    check("flush_idle.valid", 64'(OUT_VALID), 64'd0);
    check("flush_idle.ready", 64'(IN_READY), 64'd1);

    // FLUSH on the 10th CALC cycle.
    issue(mk(3'b101, 32'd1000, 32'd3, 5'd4, 32'd333, 33));
    for (int i = 1; i < 10; i++) tick();
    check("flush.in_calc", 64'(IN_READY), 64'd0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush.valid", 64'(OUT_VALID), 64'd0);
    check("flush.ready", 64'(IN_READY), 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (OUT_VALID) pulses++;
    end
    check("flush.no_pulse", 64'(pulses), 64'd0);

    // RESET mid-CALC, then a clean request.
    issue(mk(3'b101, 32'd1000, 32'd3, 5'd5, 32'd333, 33));
    for (int i = 0; i < 5; i++) tick();
    RESET = 1'b1;
    tick();
    check("rstmid.valid", 64'(OUT_VALID), 64'd0);
    check("rstmid.result", 64'(RESULT), 64'd0);
    check("rstmid.tag", 64'(OUT_TAG), 64'd0);
    check("rstmid.in_ready", 64'(IN_READY), 64'd0);
    RESET = 1'b0;
    tick();
    check("rstmid.ready_after", 64'(IN_READY), 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (OUT_VALID) pulses++;
    end
    check("rstmid.no_pulse", 64'(pulses), 64'd0);
    v = mk(3'b100, 32'd7, 32'hFFFFFFFE, 5'd21, 32'hFFFFFFFD, 33);
    run_vec("post_rst", v);
    v = mk(3'b000, 32'd6, 32'd7, 5'd22, 32'd42, ML);
    run_vec("post_rst_mul", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
